mccpu_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS-subset CPU. It replaces the single-cycle decoder with a five-state FSM that spreads each instruction over IF/ID/EXE/MEM/WB. The FSM produces per-cycle write strobes (PC, IR, register file, memory) and the datapath mux/ALU selects. It sits beside the multi-cycle datapath, which latches IR, A/B, ALUOut and MDR between states.

---
 rtl/mccpu_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mccpu_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mccpu_ctrl.sv
// mccpu_ctrl: multi-cycle control FSM for the MIPS-subset CPU.
// Each instruction walks IF -> ID -> EXE -> MEM -> WB (shortened where the
// instruction finishes early). Produces per-cycle write strobes and datapath
// selects; all outputs are combinational from state, Op, Funct and Zero.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   Op, Funct, Zero     instruction fields from IR, ALU zero flag
//   PCWrite, IRWrite, RegWrite, MemWrite   write strobes
//   EXTOp, ALUOp, NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel   datapath selects
//   state               current FSM state (debug)
//   illegal             pulse in ID for an undecodable instruction
//   instr_done          pulse in an instruction's final state
//   icount              retired-instruction counter (wraps)
module mccpu_ctrl #(
  parameter int ICNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        Op,
  input  logic [5:0]        Funct,
  input  logic              Zero,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              EXTOp,
  output logic [3:0]        ALUOp,
  output logic [1:0]        NPCOp,
  output logic [1:0]        ALUSrcA,
  output logic              ALUSrcB,
  output logic              GPRSel,
  output logic              WDSel,
  output logic [2:0]        state,
  output logic              illegal,
  output logic              instr_done,
  output logic [ICNT_W-1:0] icount
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1000;

  logic [2:0]        state_q, state_d;
  logic [ICNT_W-1:0] icount_q;

  // decode results
  logic       d_legal, d_j, d_beq, d_bne, d_lw, d_sw;
  logic [3:0] d_alu;
  logic [1:0] d_srca;
  logic       d_srcb, d_ext, d_gpr, d_wd;

  always_comb begin
    d_legal = 1'b1;
    d_j     = 1'b0;
    d_beq   = 1'b0;
    d_bne   = 1'b0;
    d_lw    = 1'b0;
    d_sw    = 1'b0;
    d_alu   = ALU_NOP;
    d_srca  = 2'b00;
    d_srcb  = 1'b0;
    d_ext   = 1'b0;
    d_gpr   = 1'b0;
    d_wd    = 1'b0;
    case (Op)
      6'b000000: begin
        case (Funct)
          6'b100000, 6'b100001: d_alu = ALU_ADD;
          6'b100010, 6'b100011: d_alu = ALU_SUB;
          6'b100100:            d_alu = ALU_AND;
          6'b100101:            d_alu = ALU_OR;
          6'b100111:            d_alu = ALU_NOR;
          6'b101010:            d_alu = ALU_SLT;
          6'b101011:            d_alu = ALU_SLTU;
          6'b000000: begin
            d_alu  = ALU_SLL;
            d_srca = 2'b01;
          end
          default:              d_legal = 1'b0;
        endcase
      end
      6'b001000: begin // addi
        d_alu = ALU_ADD; d_srcb = 1'b1; d_ext = 1'b1; d_gpr = 1'b1;
      end
      6'b001101: begin // ori
        d_alu = ALU_OR; d_srcb = 1'b1; d_gpr = 1'b1;
      end
      6'b001010: begin // slti
        d_alu = ALU_SLT; d_srcb = 1'b1; d_ext = 1'b1; d_gpr = 1'b1;
      end
      6'b001111: begin // lui: immediate routed through port A, ALU passes it
        d_alu = ALU_NOP; d_srca = 2'b10; d_gpr = 1'b1;
      end
      6'b100011: begin // lw
        d_lw = 1'b1; d_alu = ALU_ADD; d_srcb = 1'b1; d_ext = 1'b1;
        d_gpr = 1'b1; d_wd = 1'b1;
      end
      6'b101011: begin // sw
        d_sw = 1'b1; d_alu = ALU_ADD; d_srcb = 1'b1; d_ext = 1'b1;
      end
      6'b000100: begin d_beq = 1'b1; d_alu = ALU_SUB; end
      6'b000101: begin d_bne = 1'b1; d_alu = ALU_SUB; end
      6'b000010: d_j = 1'b1;
      default:   d_legal = 1'b0;
    endcase
  end

  // state register + retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IF;
      icount_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) icount_q <= icount_q + ICNT_W'(1);
    end
  end

  // next state
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = (d_j || !d_legal) ? S_IF : S_EXE;
      S_EXE: begin
        if (d_beq || d_bne)     state_d = S_IF;
        else if (d_lw || d_sw)  state_d = S_MEM;
        else                    state_d = S_WB;
      end
      S_MEM: state_d = d_lw ? S_WB : S_IF;
      S_WB:  state_d = S_IF;
      default: state_d = S_IF; // unreachable codes recover to IF
    endcase
  end

  // outputs; everything forced low while rst is high
  logic dec_en;
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    NPCOp      = 2'b00;
    illegal    = 1'b0;
    instr_done = 1'b0;
    dec_en     = 1'b0;
    EXTOp      = 1'b0;
    ALUOp      = ALU_NOP;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 1'b0;
    GPRSel     = 1'b0;
    WDSel      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        S_ID: begin
          dec_en = 1'b1;
          if (d_j) begin
            PCWrite    = 1'b1;
            NPCOp      = 2'b10;
            instr_done = 1'b1;
          end else if (!d_legal) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_EXE: begin
          dec_en = 1'b1;
          // Zero only matters here, and only for branches
          if (d_beq || d_bne) begin
            PCWrite    = d_beq ? Zero : ~Zero;
            NPCOp      = 2'b01;
            instr_done = 1'b1;
          end
        end
        S_MEM: begin
          dec_en = 1'b1;
          if (d_sw) begin
            MemWrite   = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_WB: begin
          dec_en     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
    if (dec_en) begin
      EXTOp   = d_ext;
      ALUOp   = d_alu;
      ALUSrcA = d_srca;
      ALUSrcB = d_srcb;
      GPRSel  = d_gpr;
      WDSel   = d_wd;
    end
  end

  assign state  = rst ? 3'd0 : state_q;
  assign icount = rst ? '0 : icount_q;

endmodule

// File: tb/tb_mccpu_ctrl.sv
module tb_mccpu_ctrl;
  localparam int IW = 4;

  logic clk, rst, Zero;
  logic [5:0] Op, Funct;
  logic PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ALUSrcB, GPRSel, WDSel;
  logic illegal, instr_done;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp, ALUSrcA;
  logic [2:0] state;
  logic [IW-1:0] icount;

  mccpu_ctrl #(.ICNT_W(IW)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .GPRSel(GPRSel), .WDSel(WDSel), .state(state), .illegal(illegal),
    .instr_done(instr_done), .icount(icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [IW-1:0] exp_ic;

  wire [17:0] obs = {PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ALUOp, NPCOp,
                     ALUSrcA, ALUSrcB, GPRSel, WDSel, illegal, instr_done};

  function automatic logic [17:0] ov(input logic pcw, irw, rw, mw, ext,
                                     input logic [3:0] alu, input logic [1:0] npc, srca,
                                     input logic srcb, gpr, wd, ill, done);
    return {pcw, irw, rw, mw, ext, alu, npc, srca, srcb, gpr, wd, ill, done};
  endfunction

  task automatic chk(input string tg, input logic [31:0] o, input logic [31:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tg, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from IF; check state and the full output vector each
  // cycle, then the retired count once it returns to IF.
  task automatic instr(input string tg, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int n, input logic [14:0] seq,
                       input logic [17:0] e0, input logic [17:0] e1, input logic [17:0] e2,
                       input logic [17:0] e3, input logic [17:0] e4);
    logic [17:0] ev [5];
    ev = '{e0, e1, e2, e3, e4};
    Op = op; Funct = fn; Zero = z;
    for (int i = 0; i < n; i++) begin
      #1;
      chk($sformatf("%s.state%0d", tg, i), {29'd0, state}, {29'd0, seq[3*i +: 3]});
      chk($sformatf("%s.out%0d", tg, i), {14'd0, obs}, {14'd0, ev[i]});
      tick;
    end
    exp_ic = exp_ic + 1'b1;
    #1;
    chk({tg, ".icount"}, {28'd0, icount}, {28'd0, exp_ic});
    chk({tg, ".back_if"}, {29'd0, state}, 32'd0);
  endtask

  logic [17:0] IFV, Z;
  logic [17:0] dA, dLW, dSW, dB, dLUI, dSLL;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    IFV  = ov(1,1,0,0,0,4'd0,2'd0,2'd0,0,0,0,0,0);
    Z    = '0;
    dA   = ov(0,0,0,0,0,4'd1,2'd0,2'd0,0,0,0,0,0);
    dLW  = ov(0,0,0,0,1,4'd1,2'd0,2'd0,1,1,1,0,0);
    dSW  = ov(0,0,0,0,1,4'd1,2'd0,2'd0,1,0,0,0,0);
    dB   = ov(0,0,0,0,0,4'd2,2'd0,2'd0,0,0,0,0,0);
    dLUI = ov(0,0,0,0,0,4'd0,2'd0,2'd2,0,1,0,0,0);
    dSLL = ov(0,0,0,0,0,4'd7,2'd0,2'd1,0,0,0,0,0);
    exp_ic = '0;

    rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0;
    tick; tick;
    chk("rst.out", {14'd0, obs}, 32'd0);
    chk("rst.state", {29'd0, state}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel.state", {29'd0, state}, 32'd0);
    chk("rel.icount", {28'd0, icount}, 32'd0);
    chk("rel.if", {14'd0, obs}, {14'd0, IFV});

    // add, with Zero held high to show it is ignored
    instr("add", 6'b000000, 6'b100000, 1'b1, 4, {3'd0,3'd4,3'd2,3'd1,3'd0},
          IFV, dA, dA, dA | ov(0,0,1,0,0,0,0,0,0,0,0,0,1), Z);
    instr("lw", 6'b100011, 6'b000000, 1'b0, 5, {3'd4,3'd3,3'd2,3'd1,3'd0},
          IFV, dLW, dLW, dLW, dLW | ov(0,0,1,0,0,0,0,0,0,0,0,0,1));
    instr("sw", 6'b101011, 6'b000000, 1'b0, 4, {3'd0,3'd3,3'd2,3'd1,3'd0},
          IFV, dSW, dSW, dSW | ov(0,0,0,1,0,0,0,0,0,0,0,0,1), Z);
    instr("beq_t", 6'b000100, 6'b000000, 1'b1, 3, {3'd0,3'd0,3'd2,3'd1,3'd0},
          IFV, dB, dB | ov(1,0,0,0,0,0,2'd1,0,0,0,0,0,1), Z, Z);
    instr("beq_n", 6'b000100, 6'b000000, 1'b0, 3, {3'd0,3'd0,3'd2,3'd1,3'd0},
          IFV, dB, dB | ov(0,0,0,0,0,0,2'd1,0,0,0,0,0,1), Z, Z);
    instr("bne_t", 6'b000101, 6'b000000, 1'b0, 3, {3'd0,3'd0,3'd2,3'd1,3'd0},
          IFV, dB, dB | ov(1,0,0,0,0,0,2'd1,0,0,0,0,0,1), Z, Z);
    instr("j", 6'b000010, 6'b000000, 1'b0, 2, {3'd0,3'd0,3'd0,3'd1,3'd0},
          IFV, ov(1,0,0,0,0,4'd0,2'd2,2'd0,0,0,0,0,1), Z, Z, Z);
    instr("ill_op", 6'b111111, 6'b000000, 1'b0, 2, {3'd0,3'd0,3'd0,3'd1,3'd0},
          IFV, ov(0,0,0,0,0,4'd0,2'd0,2'd0,0,0,0,1,1), Z, Z, Z);
    instr("ill_fn", 6'b000000, 6'b001000, 1'b0, 2, {3'd0,3'd0,3'd0,3'd1,3'd0},
          IFV, ov(0,0,0,0,0,4'd0,2'd0,2'd0,0,0,0,1,1), Z, Z, Z);
    instr("lui", 6'b001111, 6'b000000, 1'b0, 4, {3'd0,3'd4,3'd2,3'd1,3'd0},
          IFV, dLUI, dLUI, dLUI | ov(0,0,1,0,0,0,0,0,0,0,0,0,1), Z);
    instr("sll", 6'b000000, 6'b000000, 1'b0, 4, {3'd0,3'd4,3'd2,3'd1,3'd0},
          IFV, dSLL, dSLL, dSLL | ov(0,0,1,0,0,0,0,0,0,0,0,0,1), Z);

    // reset held for 3 cycles in the middle of an add's EXE
    Op = 6'b000000; Funct = 6'b100000; Zero = 1'b0;
    #1;
    tick; tick;
    chk("mid.exe", {29'd0, state}, 32'd2);
    rst = 1'b1;
    #1;
    chk("mid.rst_out", {14'd0, obs}, 32'd0);
    chk("mid.rst_icount", {28'd0, icount}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("mid.rst%0d.out", i), {14'd0, obs}, 32'd0);
      chk($sformatf("mid.rst%0d.state", i), {29'd0, state}, 32'd0);
    end
    rst = 1'b0;
    #1;
    exp_ic = '0;
    chk("mid.rel.state", {29'd0, state}, 32'd0);
    chk("mid.rel.icount", {28'd0, icount}, 32'd0);
    chk("mid.rel.if", {14'd0, obs}, {14'd0, IFV});

    // counter wrap: 4-bit counter driven up to all-ones, then one more
    for (int k = 0; k < 15; k++)
      instr($sformatf("jw%0d", k), 6'b000010, 6'b000000, 1'b0, 2, {3'd0,3'd0,3'd0,3'd1,3'd0},
            IFV, ov(1,0,0,0,0,4'd0,2'd2,2'd0,0,0,0,0,1), Z, Z, Z);
    chk("wrap.full", {28'd0, icount}, 32'd15);
    instr("jwrap", 6'b000010, 6'b000000, 1'b0, 2, {3'd0,3'd0,3'd0,3'd1,3'd0},
          IFV, ov(1,0,0,0,0,4'd0,2'd2,2'd0,0,0,0,0,1), Z, Z, Z);
    chk("wrap.zero", {28'd0, icount}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
